bounce_seq_checker: RTL and testbench

- Receive-side monitor for the 4-bit up/down "bounce" counter stream.
- Counter sequence after reset: 0,1,…,MAX,MAX,MAX-1,…,0,0,1,… Each endpoint is held for exactly two samples. The first 0 after reset is not repeated.
- The block samples the stream, locks onto its phase, tracks direction, counts reversals and flags any deviation.
- It sits beside the counter in the demo top level and drives status LEDs and the self-check.

---
 rtl/bounce_pkg.sv | 25 ++
 rtl/bounce_expect.sv | 83 ++++++++
 rtl/bounce_seq_checker.sv | 121 ++++++++++++
 tb/tb_bounce_seq_checker.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bounce_pkg.sv
// rtl/bounce_pkg.sv - shared types and default width for the bounce counter and its checker.
package bounce_pkg;

  localparam int BOUNCE_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    UP,
    DOWN,
    TOP,
    BOT
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_STEP  = 2'b01,
    ERR_DWELL = 2'b10
  } err_code_t;

  function automatic logic is_locked(input state_t s);
    return (s == UP) || (s == DOWN) || (s == TOP) || (s == BOT);
  endfunction

endpackage

// File: rtl/bounce_expect.sv
// rtl/bounce_expect.sv - combinational next-value prediction and classification for the checker.
// The expected port exists only when BOUNCE_ERR_CAPTURE_EN is defined.
module bounce_expect
  import bounce_pkg::*;
#(
  parameter int WIDTH = BOUNCE_WIDTH
) (
  input  state_t           state,
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] cur,
`ifdef BOUNCE_ERR_CAPTURE_EN
  output logic [WIDTH-1:0] expected,
`endif
  output logic             match,
  output state_t           next_state,
  output err_code_t        err_code
);

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  // One extra bit so MAX+1 and 0-1 never alias a legal count.
  logic [WIDTH:0] prev_x;
  logic [WIDTH:0] cur_x;
  logic [WIDTH:0] inc_x;
  logic [WIDTH:0] dec_x;
  logic [WIDTH:0] expected_x;

  assign prev_x = {1'b0, prev};
  assign cur_x  = {1'b0, cur};
  assign inc_x  = prev_x + (WIDTH + 1)'(1);
  assign dec_x  = prev_x - (WIDTH + 1)'(1);

`ifdef BOUNCE_ERR_CAPTURE_EN
  assign expected = expected_x[WIDTH-1:0];
`endif

  always_comb begin
    expected_x = cur_x;
    match      = 1'b1;
    next_state = state;
    err_code   = ERR_NONE;
    unique case (state)
      IDLE: next_state = SYNC;
      SYNC: begin
        if (cur_x == inc_x)
          next_state = (cur == MAX) ? TOP : UP;
        else if (cur_x == dec_x)
          next_state = (cur == '0) ? BOT : DOWN;
        else if ((cur == prev) && (cur == MAX))
          next_state = DOWN;
        else if ((cur == prev) && (cur == '0))
          next_state = UP;
      end
      UP: begin
        expected_x = inc_x;
        match      = (cur_x == inc_x);
        next_state = (cur == MAX) ? TOP : UP;
      end
      TOP: begin
        expected_x = {1'b0, MAX};
        match      = (cur == MAX);
        next_state = DOWN;
      end
      DOWN: begin
        expected_x = dec_x;
        match      = (cur_x == dec_x);
        next_state = (cur == '0) ? BOT : DOWN;
      end
      BOT: begin
        expected_x = '0;
        match      = (cur == '0);
        next_state = UP;
      end
      default: next_state = IDLE;
    endcase

    if (!match) begin
      next_state = SYNC;
      err_code   = ((state == TOP) || (state == BOT) || (cur == prev)) ? ERR_DWELL : ERR_STEP;
    end
  end

endmodule

// File: rtl/bounce_seq_checker.sv
// rtl/bounce_seq_checker.sv - receive-side lock/direction/reversal checker for the bounce counter.
// Defining BOUNCE_ERR_CAPTURE_EN adds err_expected/err_observed capture of the first error.
module bounce_seq_checker
  import bounce_pkg::*;
#(
  parameter int WIDTH   = BOUNCE_WIDTH,
  parameter int SWEEP_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic [WIDTH-1:0]   s_in,
  output logic               locked,
  output logic               direction,
  output logic               error,
  output logic [1:0]         err_code,
  output logic               error_sticky,
  output logic [SWEEP_W-1:0] sweep_count
`ifdef BOUNCE_ERR_CAPTURE_EN
  ,
  output logic [WIDTH-1:0]   err_expected,
  output logic [WIDTH-1:0]   err_observed
`endif
);

  state_t             state, state_d, exp_next;
  logic [WIDTH-1:0]   prev, prev_d;
  logic               exp_match;
  err_code_t          exp_code;
  err_code_t          code_q, code_d;
  logic               direction_d;
  logic               error_d;
  logic               sticky_d;
  logic [SWEEP_W-1:0] sweep_d;
`ifdef BOUNCE_ERR_CAPTURE_EN
  logic [WIDTH-1:0]   exp_val;
  logic [WIDTH-1:0]   cap_exp_d, cap_obs_d;
`endif

  bounce_expect #(.WIDTH(WIDTH)) u_expect (
    .state      (state),
    .prev       (prev),
    .cur        (s_in),
`ifdef BOUNCE_ERR_CAPTURE_EN
    .expected   (exp_val),
`endif
    .match      (exp_match),
    .next_state (exp_next),
    .err_code   (exp_code)
  );

  assign locked   = is_locked(state);
  assign err_code = code_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      prev         <= '0;
      direction    <= 1'b0;
      error        <= 1'b0;
      code_q       <= ERR_NONE;
      error_sticky <= 1'b0;
      sweep_count  <= '0;
`ifdef BOUNCE_ERR_CAPTURE_EN
      err_expected <= '0;
      err_observed <= '0;
`endif
    end else begin
      state        <= state_d;
      prev         <= prev_d;
      direction    <= direction_d;
      error        <= error_d;
      code_q       <= code_d;
      error_sticky <= sticky_d;
      sweep_count  <= sweep_d;
`ifdef BOUNCE_ERR_CAPTURE_EN
      err_expected <= cap_exp_d;
      err_observed <= cap_obs_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    prev_d  = prev;
    if (en) begin
      state_d = exp_next;
      prev_d  = s_in;
    end
  end

  always_comb begin
    direction_d = direction;
    error_d     = 1'b0;
    code_d      = code_q;
    sticky_d    = error_sticky;
    sweep_d     = sweep_count;
`ifdef BOUNCE_ERR_CAPTURE_EN
    cap_exp_d   = err_expected;
    cap_obs_d   = err_observed;
`endif
    if (en) begin
      direction_d = (exp_next == DOWN) || (exp_next == TOP);
      error_d     = !exp_match;
      if (!exp_match) begin
        code_d   = exp_code;
        sticky_d = 1'b1;
`ifdef BOUNCE_ERR_CAPTURE_EN
        // Only the first error since reset is kept.
        if (!error_sticky) begin
          cap_exp_d = exp_val;
          cap_obs_d = s_in;
        end
`endif
      end
      if (exp_match && ((state == TOP) || (state == BOT)))
        sweep_d = sweep_count + SWEEP_W'(1);
    end
  end

endmodule

// File: tb/tb_bounce_seq_checker.sv
// tb/tb_bounce_seq_checker.sv - scoreboard bench for bounce_seq_checker with directed sequences.
module tb_bounce_seq_checker;

  logic       clock;
  logic       reset;
  logic       en;
  logic [3:0] s_in;
  logic       locked;
  logic       direction;
  logic       error;
  logic [1:0] err_code;
  logic       error_sticky;
  logic [7:0] sweep_count;
`ifdef BOUNCE_ERR_CAPTURE_EN
  logic [3:0] err_expected;
  logic [3:0] err_observed;
`endif

  bounce_seq_checker dut (
    .clock        (clock),
    .reset        (reset),
    .en           (en),
    .s_in         (s_in),
    .locked       (locked),
    .direction    (direction),
    .error        (error),
    .err_code     (err_code),
    .error_sticky (error_sticky),
    .sweep_count  (sweep_count)
`ifdef BOUNCE_ERR_CAPTURE_EN
    ,
    .err_expected (err_expected),
    .err_observed (err_observed)
`endif
  );

  typedef struct packed {
    logic       lk;
    logic       dir;
    logic       err;
    logic [1:0] code;
    logic       sticky;
    logic [7:0] sweep;
    logic [7:0] cap;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_idx = 0;

  logic [1:0] e_code   = 2'd0;
  logic       e_sticky = 1'b0;
  logic [7:0] e_sweep  = 8'd0;
  logic [7:0] e_cap    = 8'd0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: every sample edge (or explicit async check) retires one expectation.
  always begin
    @(negedge clock or chk_ev);
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if ({locked, direction, error, err_code, error_sticky, sweep_count} !==
          {e.lk, e.dir, e.err, e.code, e.sticky, e.sweep}) begin
        n_err++;
        $display("FAIL out[%0d]: got lk/dir/err/code/sticky/sweep=%b/%b/%b/%0d/%b/%0d required %b/%b/%b/%0d/%b/%0d",
                 n_idx, locked, direction, error, err_code, error_sticky, sweep_count,
                 e.lk, e.dir, e.err, e.code, e.sticky, e.sweep);
      end
`ifdef BOUNCE_ERR_CAPTURE_EN
      n_cmp++;
      if ({err_expected, err_observed} !== e.cap) begin
        n_err++;
        $display("FAIL cap[%0d]: got exp/obs=%0d/%0d required %0d/%0d",
                 n_idx, err_expected, err_observed, e.cap[7:4], e.cap[3:0]);
      end
`endif
      n_idx++;
    end
  end

  task automatic push_exp(input logic lk, input logic dir, input logic err);
    exp_t e;
    e.lk = lk; e.dir = dir; e.err = err; e.code = e_code;
    e.sticky = e_sticky; e.sweep = e_sweep; e.cap = e_cap;
    q.push_back(e);
  endtask

  task automatic smp(input logic [3:0] v, input logic lk, input logic dir, input logic err);
    en = 1'b1; s_in = v;
    @(posedge clock);
    push_exp(lk, dir, err);
    #1;
  endtask

  task automatic feed(input logic [3:0] v);
    en = 1'b1; s_in = v;
    @(posedge clock);
    #1;
  endtask

  task automatic hold_cyc(input logic lk, input logic dir);
    en = 1'b0; s_in = 4'($urandom_range(15, 0));
    @(posedge clock);
    push_exp(lk, dir, 1'b0);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; en = 1'b0; s_in = 4'd0;
    repeat (2) @(negedge clock);
    #1 push_exp(1'b0, 1'b0, 1'b0); -> chk_ev; #1;
    @(negedge clock); reset = 1'b1;

    // Clean run 0..15,15,14..0,0,1,2
    smp(4'd0, 1'b0, 1'b0, 1'b0);
    for (int v = 1; v <= 14; v++) smp(4'(v), 1'b1, 1'b0, 1'b0);
    smp(4'd15, 1'b1, 1'b1, 1'b0);
    e_sweep = 8'd1; smp(4'd15, 1'b1, 1'b1, 1'b0);
    for (int v = 14; v >= 1; v--) smp(4'(v), 1'b1, 1'b1, 1'b0);
    smp(4'd0, 1'b1, 1'b0, 1'b0);
    e_sweep = 8'd2; smp(4'd0, 1'b1, 1'b0, 1'b0);
    smp(4'd1, 1'b1, 1'b0, 1'b0);
    smp(4'd2, 1'b1, 1'b0, 1'b0);

    // Skipped value 6 -> 8, relock on 9
    for (int v = 3; v <= 6; v++) smp(4'(v), 1'b1, 1'b0, 1'b0);
    e_code = 2'b01; e_sticky = 1'b1; e_cap = {4'd7, 4'd8};
    smp(4'd8, 1'b0, 1'b0, 1'b1);
    smp(4'd9, 1'b1, 1'b0, 1'b0);
    smp(4'd10, 1'b1, 1'b0, 1'b0);

    // Missing dwell at top
    for (int v = 11; v <= 14; v++) smp(4'(v), 1'b1, 1'b0, 1'b0);
    smp(4'd15, 1'b1, 1'b1, 1'b0);
    e_code = 2'b10; smp(4'd14, 1'b0, 1'b0, 1'b1);
    smp(4'd13, 1'b1, 1'b1, 1'b0);
    smp(4'd12, 1'b1, 1'b1, 1'b0);

    // Repeat 7,7 while counting down
    for (int v = 11; v >= 7; v--) smp(4'(v), 1'b1, 1'b1, 1'b0);
    smp(4'd7, 1'b0, 1'b0, 1'b1);
    for (int v = 6; v >= 1; v--) smp(4'(v), 1'b1, 1'b1, 1'b0);
    smp(4'd0, 1'b1, 1'b0, 1'b0);
    e_sweep = 8'd3; smp(4'd0, 1'b1, 1'b0, 1'b0);

    // 14 -> 0 in UP is a step error
    for (int v = 1; v <= 14; v++) smp(4'(v), 1'b1, 1'b0, 1'b0);
    e_code = 2'b01; smp(4'd0, 1'b0, 1'b0, 1'b1);

    // 15 -> 0 in TOP is a dwell error; then 0,0 relocks upward
    for (int v = 1; v <= 14; v++) smp(4'(v), 1'b1, 1'b0, 1'b0);
    smp(4'd15, 1'b1, 1'b1, 1'b0);
    e_code = 2'b10; smp(4'd0, 1'b0, 1'b0, 1'b1);
    smp(4'd0, 1'b1, 1'b0, 1'b0);

    // Enable gating mid-sweep
    for (int v = 1; v <= 3; v++) smp(4'(v), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) hold_cyc(1'b1, 1'b0);
    for (int v = 4; v <= 6; v++) smp(4'(v), 1'b1, 1'b0, 1'b0);

    // Async reset between edges with sweep_count=3
    @(negedge clock);
    #1 reset = 1'b0;
    e_code = 2'b00; e_sticky = 1'b0; e_sweep = 8'd0; e_cap = 8'd0;
    #1 push_exp(1'b0, 1'b0, 1'b0); -> chk_ev; #1;
    en = 1'b0;
    @(negedge clock); reset = 1'b1;

    // Long clean bounce: 256 reversals wrap sweep_count back to 0
    smp(4'd0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 127; c++) begin
      for (int v = 1; v <= 15; v++) feed(4'(v));
      feed(4'd15);
      for (int v = 14; v >= 0; v--) feed(4'(v));
      feed(4'd0);
    end
    e_sweep = 8'd254; smp(4'd1, 1'b1, 1'b0, 1'b0);
    for (int v = 2; v <= 14; v++) feed(4'(v));
    smp(4'd15, 1'b1, 1'b1, 1'b0);
    e_sweep = 8'd255; smp(4'd15, 1'b1, 1'b1, 1'b0);
    for (int v = 14; v >= 1; v--) feed(4'(v));
    smp(4'd0, 1'b1, 1'b0, 1'b0);
    e_sweep = 8'd0; smp(4'd0, 1'b1, 1'b0, 1'b0);

    en = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
